// File: rtl/m23lc512_spi_sram.sv
// rtl/m23lc512_spi_sram.sv - 23LC512-style SPI SRAM slave oversampled by HCLK (optional hold: M23LC512_HOLD_EN)
module m23lc512_spi_sram #(
   parameter int ADDR_W  = 16,
   parameter int PAGE_SZ = 32
) (
   input  logic HCLK,
   input  logic HRESETn,
   input  logic CS_N,
   input  logic SCK,
   input  logic SI,
   input  logic HOLD_N,
   output logic SO,
   output logic SO_OE
);

   localparam int PB = $clog2(PAGE_SZ);
   localparam logic [ADDR_W-1:0] A_ONE = 1;
   localparam logic [PB-1:0]     P_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_RDMR, S_WRMR, S_IGNORE
   } state_t;

   state_t r_state, w_state_nxt;

   logic [1:0]        r_cs_s, r_sck_s, r_si_s;
   logic              r_cs_d, r_sck_d;
   logic [3:0]        r_cnt;
   logic [6:0]        r_rx;
   logic [7:0]        r_tx;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_mode;
   logic              r_op_wr;
   logic              r_rd_act;
   logic [7:0]        r_mem [2**ADDR_W];

   logic              w_hold;
   logic              w_cs_rise, w_cs_fall, w_rise, w_fall;
   logic [7:0]        w_rx_byte;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic              w_byte_mode;
   logic              w_mem_we;
   logic              w_so_oe;

`ifdef M23LC512_HOLD_EN
   logic [1:0] r_hold_s;
   logic       r_hold;

   // Synchronize HOLD_N; hold engages only while SCK is low and releases when HOLD_N returns high
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_hold_s <= 2'b11;
         r_hold   <= 1'b0;
      end else begin
         r_hold_s <= {r_hold_s[0], HOLD_N};
         if (r_hold_s[1])
            r_hold <= 1'b0;
         else if (!r_sck_s[1])
            r_hold <= 1'b1;
      end
   end
   assign w_hold = r_hold;
`else
   logic w_unused_hold_n;
   assign w_unused_hold_n = HOLD_N;
   assign w_hold = 1'b0;
`endif

   // Two-flop synchronizers for the SPI pins plus delayed copies for edge detection
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cs_s  <= 2'b11;
         r_sck_s <= 2'b00;
         r_si_s  <= 2'b00;
         r_cs_d  <= 1'b1;
         r_sck_d <= 1'b0;
      end else begin
         r_cs_s  <= {r_cs_s[0], CS_N};
         r_sck_s <= {r_sck_s[0], SCK};
         r_si_s  <= {r_si_s[0], SI};
         r_cs_d  <= r_cs_s[1];
         r_sck_d <= r_sck_s[1];
      end
   end

   // CS_N edges win over any simultaneous SCK edge; SCK is ignored while deselected or held
   assign w_cs_rise = r_cs_s[1] & ~r_cs_d;
   assign w_cs_fall = ~r_cs_s[1] & r_cs_d;
   assign w_rise    = r_sck_s[1] & ~r_sck_d & ~r_cs_s[1] & ~w_cs_fall & ~w_hold;
   assign w_fall    = ~r_sck_s[1] & r_sck_d & ~r_cs_s[1] & ~w_cs_fall & ~w_hold;

   assign w_rx_byte   = {r_rx, r_si_s[1]};
   assign w_byte_mode = (r_mode == 2'b00);

   // Address sequencing: byte mode holds, page mode wraps low bits, otherwise full wrap
   always_comb begin
      w_addr_nxt = r_addr;
      case (r_mode)
         2'b00:   w_addr_nxt = r_addr;
         2'b10:   w_addr_nxt = {r_addr[ADDR_W-1:PB], r_addr[PB-1:0] + P_ONE};
         default: w_addr_nxt = r_addr + A_ONE;
      endcase
   end

   // State register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (w_cs_rise) begin
         w_state_nxt = S_IDLE;
      end else if (w_cs_fall) begin
         if (r_state == S_IDLE)
            w_state_nxt = S_CMD;
      end else if (w_rise) begin
         case (r_state)
            S_CMD: begin
               if (r_cnt == 4'd7) begin
                  case (w_rx_byte)
                     8'h03, 8'h02: w_state_nxt = S_ADDR;
                     8'h05:        w_state_nxt = S_RDMR;
                     8'h01:        w_state_nxt = S_WRMR;
                     default:      w_state_nxt = S_IGNORE;
                  endcase
               end
            end
            S_ADDR:       if (r_cnt == 4'd15) w_state_nxt = r_op_wr ? S_WR : S_RD;
            S_RD, S_WR:   if (r_cnt == 4'd7 && w_byte_mode) w_state_nxt = S_IGNORE;
            S_WRMR:       if (r_cnt == 4'd7) w_state_nxt = S_IGNORE;
            default:      w_state_nxt = r_state;
         endcase
      end
   end

   // Output logic: SO is only driven once a read byte has been presented
   always_comb begin
      w_so_oe = ((r_state == S_RD) || (r_state == S_RDMR)) && r_rd_act && !w_hold;
      SO_OE   = w_so_oe;
      SO      = w_so_oe & r_tx[7];
   end

   assign w_mem_we = w_rise && (r_state == S_WR) && (r_cnt == 4'd7);

   // Datapath: bit counter, shift registers, address and mode register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cnt    <= 4'd0;
         r_rx     <= 7'd0;
         r_tx     <= 8'd0;
         r_addr   <= '0;
         r_mode   <= 2'b01;
         r_op_wr  <= 1'b0;
         r_rd_act <= 1'b0;
      end else if (w_cs_rise || w_cs_fall) begin
         r_cnt    <= 4'd0;
         r_tx     <= 8'd0;
         r_rd_act <= 1'b0;
      end else if (w_rise) begin
         r_rx <= w_rx_byte[6:0];
         case (r_state)
            S_CMD: begin
               r_cnt <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
               if (r_cnt == 4'd7)
                  r_op_wr <= (w_rx_byte == 8'h02);
            end
            S_ADDR: begin
               r_addr <= {r_addr[ADDR_W-2:0], r_si_s[1]};
               r_cnt  <= (r_cnt == 4'd15) ? 4'd0 : r_cnt + 4'd1;
            end
            S_RD, S_WR, S_RDMR: begin
               r_cnt <= (r_cnt == 4'd7) ? 4'd0 : r_cnt + 4'd1;
               if (r_cnt == 4'd7 && r_state != S_RDMR)
                  r_addr <= w_addr_nxt;
            end
            S_WRMR: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd7)
                  r_mode <= w_rx_byte[7:6];
            end
            default: r_cnt <= r_cnt;
         endcase
      end else if (w_fall && (r_state == S_RD || r_state == S_RDMR)) begin
         if (r_cnt == 4'd0) begin
            r_tx     <= (r_state == S_RD) ? r_mem[r_addr] : {r_mode, 6'b0};
            r_rd_act <= 1'b1;
         end else begin
            r_tx <= {r_tx[6:0], 1'b0};
         end
      end
   end

   // Array write at each completed byte; contents survive reset
   always_ff @(posedge HCLK) begin
      if (w_mem_we)
         r_mem[r_addr] <= w_rx_byte;
   end

endmodule

// File: tb/tb_m23lc512_spi_sram.sv
// tb/tb_m23lc512_spi_sram.sv - randomized self-checking bench for m23lc512_spi_sram
module tb_m23lc512_spi_sram;

   localparam int PAGE = 32;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   logic CS_N = 1'b1;
   logic SCK = 1'b0;
   logic SI = 1'b0;
   logic HOLD_N = 1'b1;
   logic SO, SO_OE;

   m23lc512_spi_sram #(.ADDR_W(16), .PAGE_SZ(PAGE)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .CS_N(CS_N), .SCK(SCK),
      .SI(SI), .HOLD_N(HOLD_N), .SO(SO), .SO_OE(SO_OE)
   );

   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_mis = 0;

   logic [7:0] m_mem [int];
   int         m_mode = 1;
   logic [7:0] wbuf [8];
   logic [7:0] rbuf [8];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_next(input int a);
      case (m_mode)
         0:       return a;
         2:       return (a & ~(PAGE - 1)) | ((a + 1) & (PAGE - 1));
         default: return (a + 1) % 65536;
      endcase
   endfunction

   task automatic bit_x(input logic b, output logic rb, output logic oe);
      SI = b;
      repeat (4) @(negedge HCLK);
      rb = SO;
      oe = SO_OE;
      SCK = 1'b1;
      repeat (4) @(negedge HCLK);
      SCK = 1'b0;
   endtask

   task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe_all, output logic oe_any);
      logic rb, oe;
      oe_all = 1'b1;
      oe_any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         bit_x(tx[i], rb, oe);
         rx[i]  = rb;
         oe_all = oe_all & oe;
         oe_any = oe_any | oe;
      end
   endtask

   task automatic send(input logic [7:0] tx);
      logic [7:0] r;
      logic a, b;
      xfer_byte(tx, r, a, b);
   endtask

   task automatic cs_start();
      CS_N = 1'b0;
      repeat (4) @(negedge HCLK);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge HCLK);
      CS_N = 1'b1;
      repeat (6) @(negedge HCLK);
      check_val("idle_oe", SO_OE, 1'b0);
   endtask

   task automatic do_wrmr(input logic [7:0] v);
      cs_start();
      send(8'h01);
      send(v);
      cs_end();
      m_mode = int'(v[7:6]);
   endtask

   task automatic do_rdmr(input string tag, input int n);
      logic [7:0] rx;
      logic all, any;
      cs_start();
      send(8'h05);
      for (int i = 0; i < n; i++) begin
         xfer_byte(8'($urandom), rx, all, any);
         check_val({tag, "_oe"}, all, 1'b1);
         check_val({tag, "_val"}, rx, 8'((m_mode << 6) & 8'hC0));
      end
      cs_end();
   endtask

   task automatic do_write(input int a, input int n);
      logic [15:0] a16;
      int ma;
      a16 = 16'(a);
      cs_start();
      send(8'h02);
      send(a16[15:8]);
      send(a16[7:0]);
      for (int i = 0; i < n; i++) send(wbuf[i]);
      cs_end();
      ma = a;
      for (int i = 0; i < n; i++) begin
         m_mem[ma] = wbuf[i];
         if (m_mode == 0) break;
         ma = m_next(ma);
      end
   endtask

   task automatic do_read_check(input string tag, input int a, input int n);
      logic [15:0] a16;
      logic [7:0] rx;
      logic all, any;
      int ma;
      a16 = 16'(a);
      cs_start();
      send(8'h03);
      send(a16[15:8]);
      send(a16[7:0]);
      ma = a;
      for (int i = 0; i < n; i++) begin
         xfer_byte(8'($urandom), rx, all, any);
         rbuf[i] = rx;
         if (m_mode == 0 && i > 0) begin
            check_val({tag, "_oe_off"}, any, 1'b0);
         end else begin
            check_val({tag, "_oe"}, all, 1'b1);
            if (m_mem.exists(ma)) check_val({tag, "_data"}, rx, m_mem[ma]);
            ma = m_next(ma);
         end
      end
      cs_end();
   endtask

   initial begin
      logic [7:0] rx;
      logic all, any, rb, oe;
      int a, n, md;

      repeat (3) @(negedge HCLK);
      check_val("rst_so", SO, 1'b0);
      check_val("rst_oe", SO_OE, 1'b0);
      HRESETn = 1'b1;
      repeat (4) @(negedge HCLK);
      do_rdmr("rst_mode", 2);

      // sequential write/read
      wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
      do_write(16'h1234, 3);
      do_read_check("seq", 16'h1234, 3);
      check_val("seq_b0", rbuf[0], 8'hA5);
      check_val("seq_b2", rbuf[2], 8'hC3);

      // full wrap
      wbuf[0] = 8'h11; wbuf[1] = 8'h22;
      do_write(16'hFFFF, 2);
      do_read_check("wrap", 16'hFFFF, 2);
      do_read_check("wrap0", 16'h0000, 1);
      check_val("wrap_0000", rbuf[0], 8'h22);

      // page mode wraps within the 32-byte page
      wbuf[0] = 8'hEE;
      do_write(16'h0040, 1);
      do_wrmr(8'h80);
      do_rdmr("page_mode", 1);
      wbuf[0] = 8'h01; wbuf[1] = 8'h02;
      do_write(16'h003F, 2);
      do_read_check("page20", 16'h0020, 1);
      check_val("page_0020", rbuf[0], 8'h02);
      do_read_check("page40", 16'h0040, 1);
      check_val("page_0040", rbuf[0], 8'hEE);

      // byte mode: one byte then output disabled
      do_wrmr(8'h00);
      do_read_check("bytem", 16'h1234, 2);
      check_val("bytem_b0", rbuf[0], 8'hA5);

      // abort mid-byte leaves the old value
      do_wrmr(8'h40);
      wbuf[0] = 8'h77;
      do_write(16'h0010, 1);
      cs_start();
      send(8'h02); send(8'h00); send(8'h10);
      for (int i = 0; i < 5; i++) bit_x(1'b1, rb, oe);
      cs_end();
      do_read_check("abort", 16'h0010, 1);
      check_val("abort_old", rbuf[0], 8'h77);

      // unknown opcode never drives SO
      cs_start();
      send(8'hAB);
      xfer_byte(8'h00, rx, all, any);
      check_val("unk_oe0", any, 1'b0);
      xfer_byte(8'hFF, rx, all, any);
      check_val("unk_oe1", any, 1'b0);
      cs_end();

      // reset mid-transfer restores the mode register and keeps the array
      do_wrmr(8'h80);
      cs_start();
      send(8'h02); send(8'h12);
      HRESETn = 1'b0;
      CS_N = 1'b1;
      SCK = 1'b0;
      repeat (3) @(negedge HCLK);
      check_val("mid_rst_oe", SO_OE, 1'b0);
      HRESETn = 1'b1;
      repeat (6) @(negedge HCLK);
      m_mode = 1;
      do_rdmr("mid_rst_mode", 1);
      do_read_check("persist", 16'h1234, 1);
      check_val("persist_b0", rbuf[0], 8'hA5);

      // randomized transactions against the reference model
      for (int it = 0; it < 20; it++) begin
         md = $urandom_range(0, 3);
         do_wrmr(8'(md << 6));
         case ($urandom_range(0, 2))
            0:       a = $urandom_range(0, 65535);
            1:       a = 65535 - $urandom_range(0, 3);
            default: a = ($urandom_range(0, 2047) * PAGE) + PAGE - 1 - $urandom_range(0, 2);
         endcase
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         do_write(a, n);
         do_read_check("rnd", a, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
